sram_word_ctrl: RTL and testbench

Synchronous controller that drives the 32K x 8 asynchronous SRAM bus (15-bit address, bidirectional 8-bit data, active-low CS/OE/WE) on behalf of the SHA-256 datapath. It accepts one 32-bit word request at a time and turns it into four byte accesses with correct strobe sequencing and bus turnaround. For reads it reassembles the bytes into a big-endian word. It sits directly upstream of the SRAM and connects pin-for-pin to its A, IO, CS, OE and WE.

---
 rtl/sram_word_ctrl.sv | 156 +++++++++++++++
 tb/tb_sram_word_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: turns one 32-bit word request into four byte accesses on a
// 32K x 8 asynchronous SRAM (active-low CS/OE/WE, shared bidirectional IO).
// Bytes are issued in order 0..3 and reads are reassembled big-endian.
// Optional feature macro: SRAM_WORD_CTRL_BYTEMASK_EN adds a per-byte write
// enable (BE); without it every write updates all four bytes.
//
// state  | meaning
// IDLE   | bus parked, waiting for REQ
// SETUP  | address and CS asserted; write data driven or OE asserted
// STROBE | WE (write) or OE (read) active for WAIT_CYCLES clocks
// HOLD   | strobes released; write data and address held for turnaround
// FIN    | one-cycle DONE; a new request may be accepted here
module sram_word_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WR,
  input  logic [0:12] ADDR,
  input  logic [0:31] WDATA,
`ifdef SRAM_WORD_CTRL_BYTEMASK_EN
  input  logic [0:3]  BE,
`endif
  output logic [0:31] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [0:14] A,
  inout  wire  [0:7]  IO,
  output logic        CS,
  output logic        OE,
  output logic        WE
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_FIN} state_t;

  state_t      state_q, state_d;
  logic        wr_q;
  logic [0:12] addr_q;
  logic [0:31] wdata_q;
  logic [0:3]  en_q;
  logic [1:0]  k_q, k_d;
  logic [3:0]  cnt_q;
  logic [0:31] rbuf_q;
  logic [0:31] rdata_q;
  logic [0:3]  req_mask;
  logic [2:0]  nb_acc, nb_hold;
  logic        accept;
  logic        io_en;
  logic [0:7]  io_out;

  // Lowest enabled byte index at or above 'from'; 3'b100 means none left.
  function automatic logic [2:0] next_byte(input logic [0:3] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && i >= int'(from)) r = 3'(i);
    end
    return r;
  endfunction

`ifdef SRAM_WORD_CTRL_BYTEMASK_EN
  // Reads always fetch the whole word; only writes honour the mask.
  assign req_mask = WR ? BE : 4'b1111;
`else
  assign req_mask = 4'b1111;
`endif

  assign accept  = REQ && (state_q == S_IDLE || state_q == S_FIN);
  assign nb_acc  = next_byte(req_mask, 3'd0);
  assign nb_hold = next_byte(en_q, {1'b0, k_q} + 3'd1);

  // Next-state logic; a fully masked write goes straight to FIN.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (REQ) begin
          if (nb_acc[2]) begin
            state_d = S_FIN;
          end else begin
            state_d = S_SETUP;
            k_d     = nb_acc[1:0];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: if (cnt_q == 4'd0) state_d = S_HOLD;
      S_HOLD: begin
        if (nb_hold[2]) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SETUP;
          k_d     = nb_hold[1:0];
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus strobes and status decoded from the registered state.
  always_comb begin
    BUSY  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    DONE  = (state_q == S_FIN);
    CS    = !((state_q == S_SETUP) || (state_q == S_STROBE));
    OE    = !(((state_q == S_SETUP) || (state_q == S_STROBE)) && !wr_q);
    WE    = !((state_q == S_STROBE) && wr_q);
    io_en = wr_q && BUSY;
  end

  assign A      = {addr_q, k_q};
  assign RDATA  = rdata_q;
  assign io_out = wdata_q[{k_q, 3'b000} +: 8];
  assign IO     = io_en ? io_out : 8'bz;

  // State, request latches, strobe down-counter and read assembly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      en_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        wr_q    <= WR;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
        en_q    <= req_mask;
      end
      if (state_q == S_SETUP) begin
        cnt_q <= 4'(WAIT_CYCLES - 1);
      end else if (state_q == S_STROBE && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Sample on the edge that ends the final strobe cycle, while OE is still low.
      if (state_q == S_STROBE && cnt_q == 4'd0 && !wr_q) begin
        rbuf_q[{k_q, 3'b000} +: 8] <= IO;
      end
      // RDATA only changes when a read finishes, so it stays stable across writes.
      if (state_q == S_HOLD && state_d == S_FIN && !wr_q) begin
        rdata_q <= rbuf_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: two instances (WAIT_CYCLES 1 and 3) each on an
// SRAM model; word-level reference memory feeds a scoreboard of expected
// completions, and a per-cycle bus monitor checks strobe rules.
`timescale 1ns/1ps
module tb_sram_word_ctrl;
  localparam int W0 = 1;
  localparam int W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req0, wr0, busy0, done0, cs0, oe0, we0;
  logic [0:12] addr0;
  logic [0:31] wdata0, rdata0;
  logic [0:3]  be0;
  logic [0:14] a0;
  wire  [0:7]  io0;
  logic        req1, wr1, busy1, done1, cs1, oe1, we1;
  logic [0:12] addr1;
  logic [0:31] wdata1, rdata1;
  logic [0:3]  be1;
  logic [0:14] a1;
  wire  [0:7]  io1;

  logic [7:0] mem0 [0:32767];
  logic [7:0] mem1 [0:32767];
  logic [7:0] ref0 [0:32767];

  sram_word_ctrl #(.WAIT_CYCLES(W0)) u0 (
    .CLK(clk), .RST(rst), .REQ(req0), .WR(wr0), .ADDR(addr0), .WDATA(wdata0),
`ifdef SRAM_WORD_CTRL_BYTEMASK_EN
    .BE(be0),
`endif
    .RDATA(rdata0), .BUSY(busy0), .DONE(done0), .A(a0), .IO(io0),
    .CS(cs0), .OE(oe0), .WE(we0));

  sram_word_ctrl #(.WAIT_CYCLES(W1)) u1 (
    .CLK(clk), .RST(rst), .REQ(req1), .WR(wr1), .ADDR(addr1), .WDATA(wdata1),
`ifdef SRAM_WORD_CTRL_BYTEMASK_EN
    .BE(be1),
`endif
    .RDATA(rdata1), .BUSY(busy1), .DONE(done1), .A(a1), .IO(io1),
    .CS(cs1), .OE(oe1), .WE(we1));

  // Asynchronous SRAM models: drive while CS and OE low, write while CS and WE low.
  assign io0 = (!cs0 && !oe0) ? mem0[a0] : 8'bz;
  assign io1 = (!cs1 && !oe1) ? mem1[a1] : 8'bz;
  always @(posedge clk) if (!cs0 && !we0) mem0[a0] <= io0;
  always @(posedge clk) if (!cs1 && !we1) mem1[a1] <= io1;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [0:31] data;
    int          cyc;
  } exp_t;
  exp_t        sbq[$];
  int          last_exp = 0;
  logic [0:31] last_rd  = '0;

  // Completion monitor for instance 0.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk(e.rd ? "rdata" : "rdata_hold", 64'(rdata0), 64'(e.data));
      end
    end
  end

  int          we_cnt [2];
  int          oe_cnt [2];
  logic        prev_cs [2];
  logic [0:14] a_lat [2];
  logic [0:14] a_hist1[$];
  int          cs_low_cnt = 0;

  task automatic bus_chk(input int id, input int w, input logic cs, input logic oe,
                         input logic we, input logic [0:14] a, input logic [0:7] io,
                         input logic [7:0] memv);
    chk("oe_we_overlap", 64'(oe | we), 64'(1));
    if (!oe) chk("io_contention", 64'(io), 64'(memv));
    if (!prev_cs[id]) chk("addr_stable", 64'(a), 64'(a_lat[id]));
    if (prev_cs[id] && !cs) a_lat[id] = a;
    if (!cs && id == 0) cs_low_cnt++;
    if (!we) we_cnt[id]++;
    else if (we_cnt[id] != 0) begin
      chk("we_width", 64'(we_cnt[id]), 64'(w));
      we_cnt[id] = 0;
    end
    if (!oe) begin
      if (id == 1 && oe_cnt[1] == 0) a_hist1.push_back(a);
      oe_cnt[id]++;
    end else if (oe_cnt[id] != 0) begin
      chk("oe_width", 64'(oe_cnt[id]), 64'(w + 1));
      oe_cnt[id] = 0;
    end
    prev_cs[id] = cs;
  endtask

  // Bus rule monitor for both instances.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        we_cnt[i] = 0; oe_cnt[i] = 0; prev_cs[i] = 1'b1;
      end
    end else begin
      bus_chk(0, W0, cs0, oe0, we0, a0, io0, mem0[a0]);
      bus_chk(1, W1, cs1, oe1, we1, a1, io1, mem1[a1]);
    end
  end

  // Issue one request on instance 0 and record the expected completion.
  task automatic issue(input bit wr, input logic [0:12] addr, input logic [0:31] data,
                       input logic [0:3] be);
    bit          held_busy;
    int          n, acc, e;
    logic [0:3]  m;
    logic [0:31] d;
    exp_t        x;
    held_busy = busy0;
    req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = data; be0 = be;
    n = 0;
    while (busy0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", 64'(n >= 200), 64'(0));
    @(posedge clk); #1;
    acc  = cyc;
    req0 = 1'b0;
    if (held_busy) chk("b2b_accept", 64'(acc), 64'(last_exp + 1));
    m = 4'hF;
`ifdef SRAM_WORD_CTRL_BYTEMASK_EN
    if (wr) m = be;
`endif
    e = wr ? $countones(m) : 4;
    if (wr) begin
      for (int k = 0; k < 4; k++) if (m[k]) ref0[{addr, 2'(k)}] = data[k*8 +: 8];
      d = last_rd;
    end else begin
      for (int k = 0; k < 4; k++) d[k*8 +: 8] = ref0[{addr, 2'(k)}];
      last_rd = d;
    end
    x.rd = !wr; x.data = d; x.cyc = acc + e * (W0 + 2);
    last_exp = x.cyc;
    sbq.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy0 || done0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 64'(n >= 500), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    logic [0:12] ad;
    logic [0:31] ex;
    rst = 1'b1;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0; be0 = 4'hF;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0; be1 = 4'hF;
    for (int i = 0; i < 32768; i++) begin
      mem0[i] <= pat(i);
      mem1[i] <= pat(i);
      ref0[i] = pat(i);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a", 64'(a0), 64'(0));
    chk("rst_cs", 64'(cs0), 64'(1));
    chk("rst_oe", 64'(oe0), 64'(1));
    chk("rst_we", 64'(we0), 64'(1));
    chk("rst_busy", 64'(busy0), 64'(0));
    chk("rst_done", 64'(done0), 64'(0));
    chk("rst_rdata", 64'(rdata0), 64'(0));
    @(posedge clk); #1;

    // WAIT_CYCLES=3 read at the top word: address wrap and strobe widths.
    a_hist1.delete();
    req1 = 1'b1; wr1 = 1'b0; addr1 = 13'h1FFF;
    @(posedge clk); #1;
    acc = cyc; req1 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done1 && n < 100);
    chk("u1_done_cycle", 64'(cyc), 64'(acc + 4 * (W1 + 2)));
    for (int k = 0; k < 4; k++) ex[k*8 +: 8] = pat(32764 + k);
    chk("u1_rdata", 64'(rdata1), 64'(ex));
    chk("u1_byte_count", 64'(a_hist1.size()), 64'(4));
    for (int k = 0; k < 4 && k < a_hist1.size(); k++)
      chk("u1_addr_step", 64'(a_hist1[k]), 64'(32764 + k));
    @(posedge clk); #1;

    // Word write then back-to-back read of the same word.
    issue(1'b1, 13'h0004, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 13'h0004, 32'h0, 4'hF);
    drain();
    chk("mem_0010", 64'(mem0[15'h10]), 64'(8'hDE));
    chk("mem_0011", 64'(mem0[15'h11]), 64'(8'hAD));
    chk("mem_0012", 64'(mem0[15'h12]), 64'(8'hBE));
    chk("mem_0013", 64'(mem0[15'h13]), 64'(8'hEF));

    issue(1'b1, 13'h1FFF, 32'h0BADF00D, 4'hF);
    issue(1'b0, 13'h1FFF, 32'h0, 4'hF);
    drain();
    chk("mem_7fff", 64'(mem0[15'h7FFF]), 64'(8'h0D));

    // Randomized traffic over a small window so reads revisit written words.
    for (int t = 0; t < 40; t++) begin
      ad = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
    end
    drain();

    // Reset in the middle of a write: first two bytes land, the rest stay.
    issue(1'b1, 13'h0100, 32'hFFFFFFFF, 4'hF);
    drain();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 13'h0100; wdata0 = 32'h11223344; be0 = 4'hF;
    @(posedge clk); #1;
    acc = cyc; req0 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 13'h0200;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_cyc", 64'(cyc), 64'(acc + 5));
    chk("midrst_a", 64'(a0), 64'(0));
    chk("midrst_cs", 64'(cs0), 64'(1));
    chk("midrst_oe", 64'(oe0), 64'(1));
    chk("midrst_we", 64'(we0), 64'(1));
    chk("midrst_busy", 64'(busy0), 64'(0));
    chk("midrst_done", 64'(done0), 64'(0));
    chk("midrst_rdata", 64'(rdata0), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("rst_req_dropped", 64'(busy0), 64'(0));
    ref0[15'h400] = 8'h11;
    ref0[15'h401] = 8'h22;
    last_rd = '0;
    @(posedge clk); #1;
    issue(1'b0, 13'h0100, 32'h0, 4'hF);
    drain();
    chk("midrst_mem2", 64'(mem0[15'h402]), 64'(8'hFF));

`ifdef SRAM_WORD_CTRL_BYTEMASK_EN
    issue(1'b1, 13'h0020, 32'h00000000, 4'hF);
    issue(1'b1, 13'h0020, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 13'h0020, 32'h0, 4'hF);
    drain();
    chk("be_readback", 64'(last_rd), 64'(32'h00BB00DD));
    cs_low_cnt = 0;
    issue(1'b1, 13'h0021, 32'h12345678, 4'b0000);
    drain();
    chk("be_zero_cs", 64'(cs_low_cnt), 64'(0));
`endif

    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
